// File: rtl/var_delay_mem_pkg.sv
// Shared types and constant helpers for the runtime-programmable delay line.
package var_delay_pkg;

  typedef enum logic [1:0] {IDLE, FILL, RUN} state_e;

  function automatic int ptr_w(input int max_len);
    return (max_len < 2) ? 1 : $clog2(max_len);
  endfunction

  function automatic int len_w(input int max_len);
    return $clog2(max_len + 1);
  endfunction

  function automatic int clamp_delay(input int d, input int max_len);
    if (d < 1) return 1;
    if (d > max_len) return max_len;
    return d;
  endfunction

endpackage

// File: rtl/var_delay_mem_if.sv
// Sample stream and delay control bundle for var_delay_mem.
interface var_delay_mem_if
  import var_delay_pkg::*;
#(
  parameter int DW      = 8,
  parameter int MAX_LEN = 64
);
  localparam int LW = len_w(MAX_LEN);

  logic          en;
  logic          load;
  logic [LW-1:0] delay;
  logic [DW-1:0] din;
  logic [DW-1:0] dout;
  logic          valid;
  logic          filling;

  modport master (output en, load, delay, din, input dout, valid, filling);
  modport slave  (input en, load, delay, din, output dout, valid, filling);
endinterface

// File: rtl/var_delay_mem_ram.sv
// Simple dual-port register file: synchronous write, asynchronous read.
module SdpRamRf #(
  parameter int DW    = 8,
  parameter int DEPTH = 64,
  parameter int AW    = 6
) (
  input  logic          clk,
  input  logic          we_i,
  input  logic [AW-1:0] waddr_i,
  input  logic [DW-1:0] wdata_i,
  input  logic [AW-1:0] raddr_i,
  output logic [DW-1:0] rdata_o
);
  logic [DW-1:0] mem_q [DEPTH];

  always_ff @(posedge clk) begin
    if (we_i) mem_q[waddr_i] <= wdata_i;
  end

  assign rdata_o = mem_q[raddr_i];
endmodule

// File: rtl/var_delay_mem.sv
// Circular-buffer delay line with a runtime delay and a fill-tracking FSM.
module var_delay_mem
  import var_delay_pkg::*;
#(
  parameter int DW      = 8,
  parameter int MAX_LEN = 64
) (
  input logic             clk,
  input logic             rst_n,
  var_delay_mem_if.slave  bus
);
  localparam int PW = ptr_w(MAX_LEN);
  localparam int LW = len_w(MAX_LEN);

  state_e        state_q, state_d;
  logic [LW-1:0] cur_d_q, cur_d_d;
  logic [PW-1:0] wptr_q, wptr_d;
  logic [LW-1:0] fcnt_q, fcnt_d;
  logic [DW-1:0] dout_q, dout_d;
  logic          valid_q, valid_d;

  logic [LW-1:0] d_new, d_eff, dm1, n_cur;
  logic          hit;
  logic [PW-1:0] raddr;
  logic [DW-1:0] rdata;
  int            ra;

  // A load applies to the coinciding strobe, so it sees the new delay and n=0.
  always_comb begin
    d_new = LW'(clamp_delay(int'(bus.delay), MAX_LEN));
    d_eff = bus.load ? d_new : cur_d_q;
    dm1   = d_eff - LW'(1);
    n_cur = bus.load ? '0 : fcnt_q;
    hit   = (n_cur >= dm1);
    ra    = int'(wptr_q) - int'(dm1);
    if (ra < 0) ra = ra + MAX_LEN;
    raddr = PW'(ra);
  end

  SdpRamRf #(.DW(DW), .DEPTH(MAX_LEN), .AW(PW)) u_ram (
    .clk     (clk),
    .we_i    (bus.en),
    .waddr_i (wptr_q),
    .wdata_i (bus.din),
    .raddr_i (raddr),
    .rdata_o (rdata)
  );

  always_comb begin
    cur_d_d = bus.load ? d_new : cur_d_q;
    wptr_d  = wptr_q;
    fcnt_d  = fcnt_q;
    dout_d  = dout_q;
    valid_d = valid_q;
    if (bus.en) begin
      wptr_d  = (wptr_q == PW'(MAX_LEN - 1)) ? '0 : wptr_q + PW'(1);
      fcnt_d  = (n_cur == LW'(MAX_LEN)) ? n_cur : n_cur + LW'(1);
      valid_d = hit;
      // D=1 bypasses the RAM; otherwise take the pre-write read data.
      if (!hit)                   dout_d = '0;
      else if (d_eff == LW'(1))   dout_d = bus.din;
      else                        dout_d = rdata;
    end else if (bus.load) begin
      fcnt_d  = '0;
      valid_d = 1'b0;
      dout_d  = '0;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cur_d_q <= LW'(1);
      wptr_q  <= '0;
      fcnt_q  <= '0;
      dout_q  <= '0;
      valid_q <= 1'b0;
    end else begin
      cur_d_q <= cur_d_d;
      wptr_q  <= wptr_d;
      fcnt_q  <= fcnt_d;
      dout_q  <= dout_d;
      valid_q <= valid_d;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state_q <= IDLE;
    else        state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      IDLE: if (bus.en || bus.load) state_d = FILL;
      FILL: if (bus.en && hit)      state_d = RUN;
      RUN:  if (bus.load)           state_d = (bus.en && hit) ? RUN : FILL;
      default:                      state_d = IDLE;
    endcase
  end

  always_comb begin
    bus.filling = (state_q == FILL);
    bus.dout    = dout_q;
    bus.valid   = valid_q;
  end
endmodule
